led_driver: RTL and testbench

Parametrised multi-channel LED driver that generalises the free-running-counter blinker into per-channel off/on/blink/PWM modes with runtime configuration. Sits at the board top level between the control logic and the active-low LED pins. A shared prescaler sets the blink rate, and a shared PWM counter sets brightness. Configuration writes are buffered and committed only at PWM period boundaries, so outputs never glitch mid-period.

---
 rtl/led_driver.sv | 118 +++++++++++
 tb/tb_led_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_driver.sv
// Multi-channel active-low LED driver with per-channel off/on/blink/PWM modes.
// Config writes are buffered in one pending slot and committed at PWM period boundaries.
module led_driver #(
  parameter int unsigned N_LEDS   = 3,
  parameter int unsigned PRESCALE = 16777216,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned CHAN_W   = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic              input_clk,
  input  logic              input_rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHAN_W-1:0] cfg_chan,
  input  logic [1:0]        cfg_mode,
  input  logic [PWM_W-1:0]  cfg_duty,
  output logic [N_LEDS-1:0] leds
);

  localparam int unsigned PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeOn    = 2'd1,
    ModeBlink = 2'd2,
    ModePwm   = 2'd3
  } mode_e;

  logic [PRE_W-1:0]  r_pre;
  logic              r_phase;
  logic [PWM_W-1:0]  r_pwm;

  logic              r_pending;
  logic [CHAN_W-1:0] r_pend_chan;
  mode_e             r_pend_mode;
  logic [PWM_W-1:0]  r_pend_duty;

  mode_e             r_mode [N_LEDS];
  logic [PWM_W-1:0]  r_duty [N_LEDS];

  logic              w_tick;
  logic              w_accept;
  logic              w_commit;
  logic [N_LEDS-1:0] w_on;

  assign w_tick    = (r_pre == PRE_MAX);
  assign cfg_ready = ~r_pending;
  assign w_accept  = cfg_valid && cfg_ready;
  // Commit on the last PWM count so the new setting owns the whole next period.
  assign w_commit  = r_pending && (r_pwm == '1);

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      r_pre   <= '0;
      r_phase <= 1'b0;
      r_pwm   <= '0;
    end else begin
      r_pre   <= w_tick ? '0 : r_pre + PRE_W'(1);
      r_phase <= w_tick ? ~r_phase : r_phase;
      r_pwm   <= r_pwm + PWM_W'(1);
    end
  end

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      r_pending   <= 1'b0;
      r_pend_chan <= '0;
      r_pend_mode <= ModeOff;
      r_pend_duty <= '0;
    end else if (w_accept) begin
      r_pending   <= 1'b1;
      r_pend_chan <= cfg_chan;
      r_pend_mode <= mode_e'(cfg_mode);
      r_pend_duty <= cfg_duty;
    end else if (w_commit) begin
      r_pending   <= 1'b0;
    end
  end

  // Out-of-range channel indices match no entry, so such a commit is a no-op.
  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      for (int i = 0; i < int'(N_LEDS); i++) begin
        r_mode[i] <= ModeOff;
        r_duty[i] <= '0;
      end
    end else if (w_commit) begin
      for (int i = 0; i < int'(N_LEDS); i++) begin
        if (r_pend_chan == CHAN_W'(i)) begin
          r_mode[i] <= r_pend_mode;
          r_duty[i] <= r_pend_duty;
        end
      end
    end
  end

  always_comb begin
    w_on = '0;
    for (int i = 0; i < int'(N_LEDS); i++) begin
      unique case (r_mode[i])
        ModeOff:   w_on[i] = 1'b0;
        ModeOn:    w_on[i] = 1'b1;
        ModeBlink: w_on[i] = r_phase;
        ModePwm:   w_on[i] = (r_pwm < r_duty[i]);
        default:   w_on[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      leds <= '1;
    end else begin
      leds <= ~w_on;
    end
  end

endmodule

// File: tb/tb_led_driver.sv
// Directed bench for led_driver (N_LEDS=3, PRESCALE=4, PWM_W=4) with a cycle-indexed LED model.
module tb_led_driver;

  localparam int N  = 3;
  localparam int PS = 4;
  localparam int PW = 4;
  localparam int PERIOD = 1 << PW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [1:0]   cfg_chan = '0;
  logic [1:0]   cfg_mode = '0;
  logic [PW-1:0] cfg_duty = '0;
  logic [N-1:0] leds;

  int errors = 0;
  int checks = 0;
  int n_edges;
  int exp_mode [N];
  int exp_duty [N];

  led_driver #(
    .N_LEDS  (N),
    .PRESCALE(PS),
    .PWM_W   (PW)
  ) dut (
    .input_clk  (clk),
    .input_rst_n(rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_mode   (cfg_mode),
    .cfg_duty   (cfg_duty),
    .leds       (leds)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; at a negedge, pwm == n_edges % 16.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // LEDs seen at a negedge after edge n reflect the counters as they were after edge n-1.
  function automatic logic [N-1:0] model_leds(input int n);
    logic [N-1:0] on;
    int pwm_v;
    int ph;
    on    = '0;
    pwm_v = (n - 1) % PERIOD;
    ph    = ((n - 1) / PS) % 2;
    for (int i = 0; i < N; i++) begin
      case (exp_mode[i])
        1:       on[i] = 1'b1;
        2:       on[i] = (ph == 1);
        3:       on[i] = (pwm_v < exp_duty[i]);
        default: on[i] = 1'b0;
      endcase
    end
    return ~on;
  endfunction

  task automatic cfg_write(input int ch, input int mode, input int duty, input string tag);
    int w;
    w = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_chan  = 2'(ch);
    cfg_mode  = 2'(mode);
    cfg_duty  = PW'(duty);
    while (!cfg_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " ready_before_accept"}, 32'(cfg_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    w = 0;
    while (!cfg_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " commit_latency_in_range"}, 32'(w >= 1 && w <= PERIOD), 32'd1);
    if (ch < N) begin
      exp_mode[ch] = mode;
      exp_duty[ch] = duty;
    end
  endtask

  task automatic check_window(input int len, input int ch, input int exp_lows, input string tag);
    int bad;
    int lows;
    bad  = 0;
    lows = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (leds !== model_leds(n_edges)) bad++;
      if (leds[ch] === 1'b0) lows++;
    end
    chk({tag, " model_mismatches"}, 32'(bad), 32'd0);
    chk({tag, " low_cycles"}, 32'(lows), 32'(exp_lows));
  endtask

  initial begin
    int w;
    int bad;
    for (int i = 0; i < N; i++) begin
      exp_mode[i] = 0;
      exp_duty[i] = 0;
    end

    // Reset and idle behaviour.
    repeat (5) @(negedge clk);
    chk("reset leds", 32'(leds), 32'h7);
    chk("reset cfg_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (leds !== 3'b111 || cfg_ready !== 1'b1) bad++;
    end
    chk("idle 100 cycles", 32'(bad), 32'd0);

    // Out-of-range channel: accepted, committed, no visible effect.
    cfg_write(3, 1, 0, "oor ch3");
    check_window(32, 0, 0, "oor window");

    cfg_write(0, 1, 0, "ch0 on");
    check_window(32, 0, 32, "ch0 on");

    cfg_write(1, 2, 0, "ch1 blink");
    check_window(32, 1, 16, "ch1 blink");

    cfg_write(2, 3, 5, "ch2 duty5");
    check_window(32, 2, 10, "ch2 duty5");

    cfg_write(2, 3, 0, "ch2 duty0");
    check_window(16, 2, 0, "ch2 duty0");

    cfg_write(2, 3, 15, "ch2 duty15");
    check_window(16, 2, 15, "ch2 duty15");

    // Accept on pwm==15, then a second write held valid through the busy window.
    w = 0;
    @(negedge clk);
    while ((n_edges % PERIOD) != PERIOD - 1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("hs align pwm15", 32'(n_edges % PERIOD), 32'(PERIOD - 1));
    chk("hs ready at pwm15", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_chan  = 2'd2;
    cfg_mode  = 2'd3;
    cfg_duty  = 4'd5;
    @(posedge clk);
    @(negedge clk);
    chk("hs pending after accept", 32'(cfg_ready), 32'd0);
    cfg_chan = 2'd1;
    cfg_mode = 2'd1;
    cfg_duty = 4'd0;
    w = 0;
    while (!cfg_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("hs ready low cycles", 32'(w), 32'd16);
    exp_mode[2] = 3;
    exp_duty[2] = 5;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("hs second accepted", 32'(cfg_ready), 32'd0);
    w = 0;
    while (!cfg_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("hs second ready low cycles", 32'(w), 32'd15);
    exp_mode[1] = 1;
    exp_duty[1] = 0;
    check_window(32, 1, 32, "hs after second");

    // Asynchronous reset while a write is pending and ch2 is in PWM.
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_chan  = 2'd0;
    cfg_mode  = 2'd1;
    cfg_duty  = 4'd0;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("midrst pending", 32'(cfg_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst async leds", 32'(leds), 32'h7);
    chk("midrst async ready", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < N; i++) begin
      exp_mode[i] = 0;
      exp_duty[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cfg_ready !== 1'b1) bad++;
    end
    chk("postrst ready stays high", 32'(bad), 32'd0);
    check_window(40, 0, 0, "postrst pending lost");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
